// File: rtl/mem_word_port.sv
// Byte-sequencing initiator between the load/store stage and a byte-wide single-port RAM.
// Optional build macro MEM_WORD_PORT_ALIGN_CHECK_EN rejects misaligned halfword/word accesses.
module mem_word_port #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int BUS_WIDTH     = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req,
    input  logic                     we,
    input  logic [1:0]               size,
    input  logic                     loadSigned,
    input  logic [ADDRESS_WIDTH-1:0] addr,
    input  logic [31:0]              wdata,
    output logic                     ready,
    output logic                     done,
    output logic                     error,
    output logic [31:0]              rdata,
    output logic [ADDRESS_WIDTH-1:0] ramAddr,
    output logic [BUS_WIDTH-1:0]     ramDataOut,
    output logic                     ramWriteEnable,
    input  logic [BUS_WIDTH-1:0]     ramDataIn,
    input  logic                     ramBusy
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        DONE  = 3'd3,
        ERR   = 3'd4
    } state_t;

    state_t                   state_r;
    state_t                   state_s;
    logic                     we_r;
    logic [1:0]               size_r;
    logic                     sign_r;
    logic [ADDRESS_WIDTH-1:0] addr_r;
    logic [31:0]              wdata_r;
    logic [1:0]               last_r;
    logic [1:0]               k_r;
    logic [31:0]              acc_r;
    logic                     ready_r;
    logic                     done_r;
    logic                     error_r;
    logic [31:0]              rdata_r;
    logic [ADDRESS_WIDTH-1:0] ram_addr_r;
    logic [BUS_WIDTH-1:0]     ram_dout_r;
    logic                     ram_we_r;

    logic                     invalid_s;
    logic                     accept_s;
    logic                     step_s;
    logic                     last_step_s;
    logic [1:0]               k_next_s;
    logic [31:0]              rdata_s;
    logic [ADDRESS_WIDTH-1:0] ram_addr_s;
    logic [BUS_WIDTH-1:0]     ram_dout_s;
    logic                     ram_we_s;

    // Index of the final byte: 0, 1 or 3 for byte, halfword, word.
    function automatic logic [1:0] last_index(input logic [1:0] sz);
        case (sz)
            2'b00:   last_index = 2'd0;
            2'b01:   last_index = 2'd1;
            2'b10:   last_index = 2'd3;
            default: last_index = 2'd0;
        endcase
    endfunction

    // Big-endian byte k of right-aligned store data: byte 0 is the most significant.
    function automatic logic [7:0] store_byte(input logic [31:0] d, input logic [1:0] last,
                                              input logic [1:0] k);
        logic [1:0] idx;
        idx = last - k;
        case (idx)
            2'd0:    store_byte = d[7:0];
            2'd1:    store_byte = d[15:8];
            2'd2:    store_byte = d[23:16];
            2'd3:    store_byte = d[31:24];
            default: store_byte = 8'h00;
        endcase
    endfunction

    function automatic logic [31:0] extend(input logic [31:0] v, input logic [1:0] sz,
                                           input logic sg);
        case (sz)
            2'b00:   extend = {{24{sg & v[7]}}, v[7:0]};
            2'b01:   extend = {{16{sg & v[15]}}, v[15:0]};
            default: extend = v;
        endcase
    endfunction

`ifdef MEM_WORD_PORT_ALIGN_CHECK_EN
    function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] lsb);
        case (sz)
            2'b01:   misaligned = lsb[0];
            2'b10:   misaligned = (lsb != 2'b00);
            default: misaligned = 1'b0;
        endcase
    endfunction
`endif

    // Request qualification and per-byte handshake events.
    always_comb begin
`ifdef MEM_WORD_PORT_ALIGN_CHECK_EN
        invalid_s = (size == 2'b11) || misaligned(size, addr[1:0]);
`else
        invalid_s = (size == 2'b11);
`endif
        accept_s    = (state_r == IDLE) && req && !invalid_s;
        step_s      = (state_r == WAIT) && !ramBusy;
        last_step_s = step_s && (k_r == last_r);
        k_next_s    = k_r + 2'd1;
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (req) begin
                    state_s = invalid_s ? ERR : ISSUE;
                end else begin
                    state_s = IDLE;
                end
            end
            ISSUE: state_s = WAIT;
            WAIT: begin
                if (ramBusy) begin
                    state_s = WAIT;
                end else if (k_r == last_r) begin
                    state_s = DONE;
                end else begin
                    state_s = ISSUE;
                end
            end
            DONE:    state_s = IDLE;
            ERR:     state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Output logic, computed from the next state so every port comes straight from a flop.
    always_comb begin
        ram_addr_s = ram_addr_r;
        ram_dout_s = ram_dout_r;
        ram_we_s   = 1'b0;
        rdata_s    = rdata_r;
        if (accept_s) begin
            ram_addr_s = addr;
            ram_we_s   = we;
            ram_dout_s = we ? store_byte(wdata, last_index(size), 2'd0) : ram_dout_r;
        end else if (step_s && !last_step_s) begin
            ram_addr_s = addr_r + {{(ADDRESS_WIDTH-2){1'b0}}, k_next_s};
            ram_we_s   = we_r;
            ram_dout_s = we_r ? store_byte(wdata_r, last_r, k_next_s) : ram_dout_r;
        end else begin
            ram_addr_s = ram_addr_r;
        end
        if (last_step_s && !we_r) begin
            rdata_s = extend({acc_r[23:0], ramDataIn}, size_r, sign_r);
        end else begin
            rdata_s = rdata_r;
        end
    end

    // Latched request, byte index, load accumulator and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            we_r       <= 1'b0;
            size_r     <= 2'b00;
            sign_r     <= 1'b0;
            addr_r     <= '0;
            wdata_r    <= 32'h0000_0000;
            last_r     <= 2'd0;
            k_r        <= 2'd0;
            acc_r      <= 32'h0000_0000;
            ready_r    <= 1'b1;
            done_r     <= 1'b0;
            error_r    <= 1'b0;
            rdata_r    <= 32'h0000_0000;
            ram_addr_r <= '0;
            ram_dout_r <= '0;
            ram_we_r   <= 1'b0;
        end else begin
            if (accept_s) begin
                we_r    <= we;
                size_r  <= size;
                sign_r  <= loadSigned;
                addr_r  <= addr;
                wdata_r <= wdata;
                last_r  <= last_index(size);
                k_r     <= 2'd0;
                acc_r   <= 32'h0000_0000;
            end else if (step_s) begin
                k_r   <= k_next_s;
                acc_r <= we_r ? acc_r : {acc_r[23:0], ramDataIn};
            end
            ready_r    <= (state_s == IDLE);
            done_r     <= (state_s == DONE);
            error_r    <= (state_s == ERR);
            rdata_r    <= rdata_s;
            ram_addr_r <= ram_addr_s;
            ram_dout_r <= ram_dout_s;
            ram_we_r   <= ram_we_s;
        end
    end

    assign ready          = ready_r;
    assign done           = done_r;
    assign error          = error_r;
    assign rdata          = rdata_r;
    assign ramAddr        = ram_addr_r;
    assign ramDataOut     = ram_dout_r;
    assign ramWriteEnable = ram_we_r;

endmodule

// File: tb/tb_mem_word_port.sv
// Scoreboard bench for mem_word_port: a RAM model, expected completions and expected writes.
module tb_mem_word_port;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic        loadSigned;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ready;
    logic        done;
    logic        error;
    logic [31:0] rdata;
    logic [31:0] ramAddr;
    logic [7:0]  ramDataOut;
    logic        ramWriteEnable;
    logic [7:0]  ramDataIn;
    logic        ramBusy;

    typedef struct {
        logic        is_err;
        logic [31:0] rdata;
        int          cyc;
    } exp_t;
    typedef struct {
        logic [31:0] a;
        logic [7:0]  d;
        int          cyc;
    } wr_t;

    exp_t eq[$];
    wr_t  wq[$];
    exp_t e;
    wr_t  w;
    logic [7:0]  mem [logic [31:0]];
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] last_rdata;
    logic [31:0] a0;

    mem_word_port #(.ADDRESS_WIDTH(32), .BUS_WIDTH(8)) dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .size(size),
        .loadSigned(loadSigned), .addr(addr), .wdata(wdata),
        .ready(ready), .done(done), .error(error), .rdata(rdata),
        .ramAddr(ramAddr), .ramDataOut(ramDataOut), .ramWriteEnable(ramWriteEnable),
        .ramDataIn(ramDataIn), .ramBusy(ramBusy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: RAM model plus scoreboard pops, sampled on the falling edge.
    always @(negedge clk) begin
        if (reset) begin
            if (ramWriteEnable) begin
                mem[ramAddr] = ramDataOut;
                if (wq.size() == 0) begin
                    check("unexpected_write", {31'd0, ramWriteEnable}, 32'd0);
                end else begin
                    w = wq.pop_front();
                    check("write_addr", ramAddr, w.a);
                    check("write_data", {24'd0, ramDataOut}, {24'd0, w.d});
                    check("write_cycle", cyc, w.cyc);
                end
            end
            if (done || error) begin
                if (eq.size() == 0) begin
                    check("unexpected_completion", {30'd0, done, error}, 32'd0);
                end else begin
                    e = eq.pop_front();
                    check("error_flag", {31'd0, error}, {31'd0, e.is_err});
                    check("done_flag", {31'd0, done}, {31'd0, !e.is_err});
                    check("rdata", rdata, e.rdata);
                    check("completion_cycle", cyc, e.cyc);
                end
            end
        end
        ramDataIn = mem.exists(ramAddr) ? mem[ramAddr] : 8'h00;
    end

    // Drive one request at a falling edge; lat is the cycle number in which done/error shows.
    task automatic issue(input logic w_i, input logic [1:0] s, input logic sg,
                         input logic [31:0] a, input logic [31:0] d, input logic is_err,
                         input logic [31:0] exp_r, input int lat, input int max_wr,
                         input logic expect_end);
        int   n;
        int   d0;
        wr_t  x;
        exp_t y;
        d0 = cyc;
        n  = (s == 2'b10) ? 4 : (s == 2'b01) ? 2 : 1;
        if (w_i && !is_err) begin
            for (int k = 0; k < n && k < max_wr; k++) begin
                x.a   = a + k;
                x.d   = (s == 2'b10) ? d[31-8*k -: 8] : (s == 2'b01) ? (k == 0 ? d[15:8] : d[7:0]) : d[7:0];
                x.cyc = d0 + 1 + 2 * k;
                wq.push_back(x);
            end
        end
        if (expect_end) begin
            y.is_err = is_err;
            y.rdata  = exp_r;
            y.cyc    = d0 + lat;
            eq.push_back(y);
            if (!is_err && !w_i) last_rdata = exp_r;
        end
        we = w_i; size = s; loadSigned = sg; addr = a; wdata = d; req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        we = 1'b0; wdata = 32'h0; addr = 32'h0;
    endtask

    task automatic wait_idle();
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ready && eq.size() == 0 && wq.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        check("idle_timeout", {31'd0, ok}, 32'd1);
    endtask

    task automatic check_reset_outputs();
        check("rst_ready", {31'd0, ready}, 32'd1);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_error", {31'd0, error}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_ramAddr", ramAddr, 32'd0);
        check("rst_ramDataOut", {24'd0, ramDataOut}, 32'd0);
        check("rst_ramWriteEnable", {31'd0, ramWriteEnable}, 32'd0);
    endtask

    initial begin
        reset = 1'b1; req = 1'b0; we = 1'b0; size = 2'b00; loadSigned = 1'b0;
        addr = 32'h0; wdata = 32'h0; ramBusy = 1'b0; ramDataIn = 8'h00;
        last_rdata = 32'h0;
        #1 reset = 1'b0;
        #1 check_reset_outputs();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        issue(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, last_rdata, 9, 4, 1'b1);
        wait_idle();
        issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF, 9, 0, 1'b1);
        wait_idle();
        issue(1'b0, 2'b00, 1'b1, 32'h12, 32'h0, 1'b0, 32'hFFFFFFBE, 3, 0, 1'b1);
        wait_idle();
        issue(1'b0, 2'b00, 1'b0, 32'h12, 32'h0, 1'b0, 32'h000000BE, 3, 0, 1'b1);
        wait_idle();

        // Halfword load with the RAM busy for the first three WAIT cycles.
        issue(1'b0, 2'b01, 1'b0, 32'h10, 32'h0, 1'b0, 32'h0000DEAD, 8, 0, 1'b1);
        @(negedge clk);
        ramBusy = 1'b1;
        repeat (3) @(negedge clk);
        ramBusy = 1'b0;
        wait_idle();

        a0 = ramAddr;
`ifdef MEM_WORD_PORT_ALIGN_CHECK_EN
        issue(1'b0, 2'b01, 1'b0, 32'h11, 32'h0, 1'b1, last_rdata, 1, 0, 1'b1);
        wait_idle();
        check("misaligned_no_ram_activity", ramAddr, a0);
`else
        issue(1'b0, 2'b01, 1'b0, 32'h11, 32'h0, 1'b0, 32'h0000ADBE, 5, 0, 1'b1);
        wait_idle();
`endif

        a0 = ramAddr;
        issue(1'b1, 2'b11, 1'b0, 32'h40, 32'h12345678, 1'b1, last_rdata, 1, 0, 1'b1);
        wait_idle();
        check("reserved_size_no_ram_activity", ramAddr, a0);

`ifdef MEM_WORD_PORT_ALIGN_CHECK_EN
        issue(1'b1, 2'b10, 1'b0, 32'hFFFFFFFE, 32'h11223344, 1'b1, last_rdata, 1, 0, 1'b1);
        wait_idle();
`else
        issue(1'b1, 2'b10, 1'b0, 32'hFFFFFFFE, 32'h11223344, 1'b0, last_rdata, 9, 4, 1'b1);
        wait_idle();
        issue(1'b0, 2'b10, 1'b0, 32'hFFFFFFFE, 32'h0, 1'b0, 32'h11223344, 9, 0, 1'b1);
        wait_idle();
`endif

        // Reset in the WAIT after the second byte of a word store.
        issue(1'b1, 2'b10, 1'b0, 32'h20, 32'hCAFEF00D, 1'b0, last_rdata, 9, 2, 1'b0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1 check_reset_outputs();
        check("abort_writes_drained", wq.size(), 32'd0);
        eq.delete();
        wq.delete();
        last_rdata = 32'h0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        issue(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b0, 32'hCAFE0000, 9, 0, 1'b1);
        wait_idle();

        check("pending_completions", eq.size(), 32'd0);
        check("pending_writes", wq.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_word_port.md
# mem_word_port

Initiator side of the byte-wide single-port RAM interface. Accepts one byte, halfword or word load/store from the CPU pipeline and sequences it as 1, 2 or 4 byte transfers on the RAM's read/write port A. Drives the address, write data and write enable, and watches busy. Sits between the MIPS load/store stage and the RAM.

## Interface
- `ADDRESS_WIDTH`, 32, width of CPU and RAM addresses
- `BUS_WIDTH`, 8, RAM data bus width; fixed at 8, other values unsupported
- `clk` in 1: single clock, rising edge
- `reset` in 1: asynchronous, active-low reset
- `req` in 1: CPU request strobe; sampled only when `ready`=1
- `we` in 1: 1 = store, 0 = load
- `size` in 2: 00 byte, 01 halfword, 10 word, 11 reserved (treated as error)
- `loadSigned` in 1: sign-extend load result
- `addr` in ADDRESS_WIDTH: byte address of access
- `wdata` in 32: store data, right-aligned
- `ready` out 1: idle, will accept `req`
- `done` out 1: one-cycle pulse, access complete
- `error` out 1: one-cycle pulse, access rejected
- `rdata` out 32: load result; valid while `done`=1, held until next accepted load
- `ramAddr` out ADDRESS_WIDTH: RAM port A address
- `ramDataOut` out 8: RAM write data
- `ramWriteEnable` out 1: RAM write strobe
- `ramDataIn` in 8: RAM port A read data
- `ramBusy` in 1: RAM port A busy

## Operation
- States: IDLE, ISSUE, WAIT, DONE, ERR.
- IDLE: `ready`=1. On `req`=1, latch `we`, `size`, `loadSigned`, `addr`, `wdata`, and set byte count N (1/2/4) and index k=0. Go to ISSUE, or ERR if `size`=11 (or misaligned, see Configuration).
- ISSUE: `ramAddr` = latched addr + k, modulo 2^ADDRESS_WIDTH (wrap). For a store, `ramWriteEnable`=1 with `ramDataOut` = byte k. Go to WAIT.
- WAIT: `ramAddr` held, `ramWriteEnable`=0. Stay while `ramBusy`=1. When `ramBusy`=0:
  - for a load, capture `ramDataIn` as byte k;
  - then k++, and go to ISSUE if k<N, else DONE.
- Byte order is big-endian: byte 0 is the most significant byte.
  - Word: byte 0 = `wdata[31:24]` ... byte 3 = `wdata[7:0]`.
  - Half: `wdata[15:8]`, then `[7:0]`.
  - Byte: `wdata[7:0]`.
- Load result is right-aligned. Upper bits are zero, or copies of the result MSB when `loadSigned`=1.
- DONE: `done`=1 for one cycle, `rdata` updated (loads only; stores leave `rdata` unchanged). Go to IDLE.
- ERR: `error`=1 for one cycle, no RAM transaction, `rdata` unchanged. Go to IDLE.
- `req` while not IDLE is ignored; no queuing.

## Timing
- Reset (async, `reset`=0) forces IDLE immediately. Output values during reset:
  - `ready`=1;
  - `done`=0, `error`=0;
  - `rdata`=0;
  - `ramAddr`=0, `ramDataOut`=0, `ramWriteEnable`=0.
- Reset mid-transfer abandons the access; bytes already written stay written.
- With `ramBusy`=0 throughout, request accepted at edge 0:
  - ISSUE runs in cycles 1,3,5,7 and WAIT in cycles 2,4,6,8;
  - `done` is high in cycle 2N+1: byte cycle 3, half cycle 5, word cycle 9;
  - `ready` returns in cycle 2N+2.
- Each busy cycle in WAIT adds one cycle of latency.
- Error path: `error` high in cycle 1, `ready` back in cycle 2.
- `ramWriteEnable` is high for exactly one cycle per stored byte and never during loads.
- All outputs are registered.

## Configuration
- `MEM_WORD_PORT_ALIGN_CHECK_EN` defined:
  - a halfword with `addr[0]`=1 goes to ERR;
  - a word with `addr[1:0]`≠0 goes to ERR.
- Not defined: misaligned accesses proceed byte-by-byte from the given address, with address wrap applied. `size`=11 goes to ERR in both builds.

## Test plan
- Reset then word store `addr`=0x10, `wdata`=0xDEADBEEF, busy=0 -> RAM writes DE,AD,BE,EF at 0x10..0x13; `ramWriteEnable` pulses in cycles 1,3,5,7; `done` in cycle 9.
- Word load from 0x10 after the store above -> `rdata`=0xDEADBEEF in cycle 9. Byte load from 0x12 with `loadSigned`=1 -> `rdata`=0xFFFFFFBE; with `loadSigned`=0 -> 0x000000BE.
- Half load at 0x10 with `ramBusy` held high 3 cycles in the first WAIT -> `done` in cycle 8; `rdata`=0x0000DEAD.
- Half load at 0x11: with the macro -> `error` in cycle 1, no `ramAddr` activity; without it -> `rdata`=0x0000ADBE. `size`=11 -> `error` in both builds.
- Word store at 0xFFFFFFFE without the macro -> bytes written at 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1.
- `reset` asserted mid-word-store after 2 bytes -> outputs take their reset values immediately, `ready`=1; a new request completes normally.
